// File: rtl/viterbi_tbck.sv
// viterbi_tbck: K=3 traceback and bit reordering; VITERBI_TBCK_LIFO_EN adds LIFO/OUT for oldest-first output.
module viterbi_tbck #(
  parameter int NUM_ST = 4,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_mem,
  input  logic [NUM_ST-1:0] dec_in,
  input  logic              en_tbck,
  input  logic [1:0]        start_state,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);
`ifdef VITERBI_TBCK_LIFO_EN
  typedef enum logic [1:0] {IDLE, TRACE, OUT, DONE} st_t;
`else
  typedef enum logic [1:0] {IDLE, TRACE, DONE} st_t;
`endif
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] ONE = 1;
  st_t st, nxt;
  logic [NUM_ST-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, wp_post;
  logic [AW:0] cnt, cnt_post, k;
  logic [1:0] cur, cur_nxt;
  logic tbck_q, rise, wr, d;
`ifdef VITERBI_TBCK_LIFO_EN
  logic lifo [DEPTH];
  logic [AW:0] sp, sp_m2;
  assign sp_m2 = sp - 2'd2;
`endif
  assign wr = (st == IDLE) && en_mem;
  assign rise = en_tbck && !tbck_q;
  // the write on a rise edge counts toward the traceback just requested
  assign wp_post = wr ? wp + 1'b1 : wp;
  assign cnt_post = (wr && cnt != FULL) ? cnt + 1'b1 : cnt;
  assign d = mem[rp][cur];
  assign cur_nxt = (st == IDLE) ? start_state : {cur[0], d};
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  nxt = !rise ? IDLE : (cnt_post != '0 ? TRACE : DONE);
`ifdef VITERBI_TBCK_LIFO_EN
      TRACE: nxt = (k == ONE) ? OUT : TRACE;
      OUT:   nxt = (sp == ONE) ? DONE : OUT;
`else
      TRACE: nxt = (k == ONE) ? DONE : TRACE;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= dec_in;
`ifdef VITERBI_TBCK_LIFO_EN
  always_ff @(posedge clk) if (st == TRACE) lifo[sp[AW-1:0]] <= cur[1];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      k <= '0;
      cur <= '0;
      tbck_q <= 1'b0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef VITERBI_TBCK_LIFO_EN
      sp <= '0;
`endif
    end else begin
      st <= nxt;
      tbck_q <= en_tbck;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      cnt <= (st == DONE) ? '0 : cnt_post;
      wp <= (st == DONE) ? '0 : wp_post;
      if (st == IDLE && rise) begin
        cur <= start_state;
        rp <= wp_post - 1'b1;
        k <= cnt_post;
      end else if (st == TRACE) begin
        cur <= cur_nxt;
        rp <= rp - 1'b1;
        k <= k - 1'b1;
      end
`ifdef VITERBI_TBCK_LIFO_EN
      // bit_out presents the stack top as it stands after this edge
      sp <= (st == TRACE) ? sp + 1'b1 : (st == OUT) ? sp - 1'b1 : '0;
      bit_valid <= nxt == OUT;
      bit_out <= (nxt == OUT) && ((st == TRACE) ? cur[1] : lifo[sp_m2[AW-1:0]]);
`else
      bit_valid <= nxt == TRACE;
      bit_out <= (nxt == TRACE) && cur_nxt[1];
`endif
    end
  end
endmodule

// File: tb/tb_viterbi_tbck.sv
// tb_viterbi_tbck: random and directed tracebacks against a queue-based trellis model.
module tb_viterbi_tbck;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst, en_mem, en_tbck, bit_out, bit_valid, busy, done;
  logic [3:0] dec_in;
  logic [1:0] start_state;
  int checks = 0;
  int failures = 0;
  logic [3:0] hist [$];
  bit exp_q [$];

  always #5 clk = ~clk;

  viterbi_tbck #(.NUM_ST(4), .DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .rst(rst), .en_mem(en_mem), .dec_in(dec_in), .en_tbck(en_tbck),
    .start_state(start_state), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void hpush(input logic [3:0] v);
    hist.push_back(v);
    if (hist.size() > DEPTH) void'(hist.pop_front());
  endfunction

  task automatic wr(input logic [3:0] v);
    en_mem = 1'b1;
    dec_in = v;
    tick;
    en_mem = 1'b0;
    hpush(v);
  endtask

  // decoded bit = s div 2, predecessor = (s mod 2)*2 + decision
  function automatic void model(input logic [1:0] st);
    int s;
    logic [3:0] v;
    bit b;
    exp_q.delete();
    s = int'(st);
    for (int i = hist.size() - 1; i >= 0; i--) begin
      v = hist[i];
      b = bit'(s / 2);
      s = (s % 2) * 2 + int'(v[s]);
`ifdef VITERBI_TBCK_LIFO_EN
      exp_q.push_front(b);
`else
      exp_q.push_back(b);
`endif
    end
  endfunction

  task automatic run_trace(input logic [1:0] st, input bit sim, input logic [3:0] sv, input bit noise);
    int n, cend, idx;
    bit v, dn, bz;
    en_tbck = 1'b0;
    tick;
    if (sim) begin
      en_mem = 1'b1;
      dec_in = sv;
      hpush(sv);
    end
    model(st);
    n = exp_q.size();
    en_tbck = 1'b1;
    start_state = st;
    tick;
    en_mem = 1'b0;
    start_state = 2'($urandom);
`ifdef VITERBI_TBCK_LIFO_EN
    cend = 2 * n + 2;
`else
    cend = n + 2;
`endif
    for (int c = 1; c <= cend; c++) begin
`ifdef VITERBI_TBCK_LIFO_EN
      v = (c > n) && (c <= 2 * n);
      idx = c - n - 1;
      dn = c == 2 * n + 1;
      bz = c <= 2 * n + 1;
`else
      v = c <= n;
      idx = c - 1;
      dn = c == n + 1;
      bz = c <= n + 1;
`endif
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(bz));
      chk($sformatf("valid c%0d", c), 32'(bit_valid), 32'(v));
      chk($sformatf("done c%0d", c), 32'(done), 32'(dn));
      if (v) chk($sformatf("bit c%0d", c), 32'(bit_out), 32'(exp_q[idx]));
      en_mem = noise && (c < cend);
      dec_in = 4'($urandom);
      tick;
    end
    en_mem = 1'b0;
    hist.delete();
  endtask

  initial begin
    rst = 1'b1;
    en_mem = 1'b0;
    en_tbck = 1'b0;
    dec_in = '0;
    start_state = '0;
    repeat (3) tick;
    chk("rst bit_out", 32'(bit_out), 0);
    chk("rst valid", 32'(bit_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    rst = 1'b0;
    tick;
    repeat (4) wr(4'hF);
    run_trace(2'b10, 1'b0, 4'h0, 1'b0);
    repeat (8) wr(4'h0);
    run_trace(2'b00, 1'b0, 4'h0, 1'b0);
    repeat (3) wr(4'hF);
    repeat (8) wr(4'h0);
    run_trace(2'b11, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      chk("hold busy", 32'(busy), 0);
      chk("hold valid", 32'(bit_valid), 0);
      tick;
    end
    repeat (3) wr(4'($urandom));
    run_trace(2'($urandom), 1'b0, 4'h0, 1'b0);
    repeat (5) wr(4'($urandom));
    run_trace(2'($urandom), 1'b0, 4'h0, 1'b1);
    run_trace(2'($urandom), 1'b0, 4'h0, 1'b0);
    repeat (2) wr(4'($urandom));
    run_trace(2'($urandom), 1'b1, 4'($urandom), 1'b0);
    repeat (6) wr(4'($urandom));
    en_tbck = 1'b0;
    tick;
    en_tbck = 1'b1;
    start_state = 2'($urandom);
    tick;
`ifdef VITERBI_TBCK_LIFO_EN
    repeat (7) tick;
`else
    repeat (2) tick;
`endif
    rst = 1'b1;
    en_tbck = 1'b0;
    tick;
    rst = 1'b0;
    chk("midrst bit_out", 32'(bit_out), 0);
    chk("midrst valid", 32'(bit_valid), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    hist.delete();
    run_trace(2'($urandom), 1'b0, 4'h0, 1'b0);
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 12)) wr(4'($urandom));
      run_trace(2'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
